// File: rtl/mem_arbiter_pkg.sv
// Shared operation encoding for the arbiter's requester and memory buses.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        Op_INVALID = 2'd0,
        Op_READ    = 2'd1,
        Op_WRITE   = 2'd2
    } op_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the memory-side bus around mem_arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);

    op_e               req_op_0;
    logic [ADDR_W-1:0] req_addr_0;
    logic [DATA_W-1:0] req_data_0;
    logic              req_gnt_0;
    logic              rsp_vld_0;
    logic [DATA_W-1:0] rsp_data_0;

    op_e               req_op_1;
    logic [ADDR_W-1:0] req_addr_1;
    logic [DATA_W-1:0] req_data_1;
    logic              req_gnt_1;
    logic              rsp_vld_1;
    logic [DATA_W-1:0] rsp_data_1;

    logic              mem_rst;
    op_e               mem_req_op;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_rsp_vld;
    logic [DATA_W-1:0] mem_rsp_data;

    // Environment side: requesters plus the memory block.
    modport master (
        output req_op_0, req_addr_0, req_data_0,
        input  req_gnt_0, rsp_vld_0, rsp_data_0,
        output req_op_1, req_addr_1, req_data_1,
        input  req_gnt_1, rsp_vld_1, rsp_data_1,
        input  mem_rst, mem_req_op, mem_req_addr, mem_req_data,
        output mem_rsp_vld, mem_rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_op_0, req_addr_0, req_data_0,
        output req_gnt_0, rsp_vld_0, rsp_data_0,
        input  req_op_1, req_addr_1, req_data_1,
        output req_gnt_1, rsp_vld_1, rsp_data_1,
        output mem_rst, mem_req_op, mem_req_addr, mem_req_data,
        input  mem_rsp_vld, mem_rsp_data
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters,
// sequencing the memory clear after reset and steering read data back by tag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_clr_cnt;
    logic              r_rr_ptr;
    logic              r_src_q;
    logic              r_rd_tag_q;
    logic              r_mem_rst;
    op_e               r_mem_req_op;
    logic [ADDR_W-1:0] r_mem_req_addr;
    logic [DATA_W-1:0] r_mem_req_data;

    logic w_pend_0;
    logic w_pend_1;
    logic w_gnt_0;
    logic w_gnt_1;
    logic w_rsp_vld_0;
    logic w_rsp_vld_1;

    assign w_pend_0 = (bus.req_op_0 != Op_INVALID);
    assign w_pend_1 = (bus.req_op_1 != Op_INVALID);

    // Grant: lone requester wins outright, contention resolved by rr_ptr.
    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        if (r_state == ST_RUN) begin
            if (w_pend_0 && w_pend_1) begin
                w_gnt_0 = ~r_rr_ptr;
                w_gnt_1 = r_rr_ptr;
            end else begin
                w_gnt_0 = w_pend_0;
                w_gnt_1 = w_pend_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_INIT;
            r_clr_cnt      <= '0;
            r_rr_ptr       <= 1'b0;
            r_src_q        <= 1'b0;
            r_rd_tag_q     <= 1'b0;
            r_mem_rst      <= 1'b1;
            r_mem_req_op   <= Op_INVALID;
            r_mem_req_addr <= '0;
            r_mem_req_data <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_mem_rst <= 1'b1;
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state   <= ST_RUN;
                        r_mem_rst <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    r_mem_rst <= 1'b0;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase

            // Issue the granted op; the pointer always moves to the loser.
            if (w_gnt_0) begin
                r_mem_req_op   <= bus.req_op_0;
                r_mem_req_addr <= bus.req_addr_0;
                r_mem_req_data <= bus.req_data_0;
                r_src_q        <= 1'b0;
                r_rr_ptr       <= 1'b1;
            end else if (w_gnt_1) begin
                r_mem_req_op   <= bus.req_op_1;
                r_mem_req_addr <= bus.req_addr_1;
                r_mem_req_data <= bus.req_data_1;
                r_src_q        <= 1'b1;
                r_rr_ptr       <= 1'b0;
            end else begin
                r_mem_req_op   <= Op_INVALID;
            end

            if (r_mem_req_op == Op_READ) begin
                r_rd_tag_q <= r_src_q;
            end
        end
    end

    // Responses only route while running so nothing leaks out across a reset.
    assign w_rsp_vld_0 = bus.mem_rsp_vld && (r_state == ST_RUN) && (r_rd_tag_q == 1'b0);
    assign w_rsp_vld_1 = bus.mem_rsp_vld && (r_state == ST_RUN) && (r_rd_tag_q == 1'b1);

    assign bus.req_gnt_0    = w_gnt_0;
    assign bus.req_gnt_1    = w_gnt_1;
    assign bus.rsp_vld_0    = w_rsp_vld_0;
    assign bus.rsp_vld_1    = w_rsp_vld_1;
    assign bus.rsp_data_0   = w_rsp_vld_0 ? bus.mem_rsp_data : '0;
    assign bus.rsp_data_1   = w_rsp_vld_1 ? bus.mem_rsp_data : '0;
    assign bus.mem_rst      = r_mem_rst;
    assign bus.mem_req_op   = r_mem_req_op;
    assign bus.mem_req_addr = r_mem_req_addr;
    assign bus.mem_req_data = r_mem_req_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64x8 memory on the far side.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned CLEAR_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DATA_W-1:0] mem [64];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory: synchronous clear, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            bus.mem_rsp_vld  <= 1'b0;
            bus.mem_rsp_data <= '0;
        end else begin
            bus.mem_rsp_vld  <= (bus.mem_req_op == Op_READ);
            bus.mem_rsp_data <= (bus.mem_req_op == Op_READ) ? mem[bus.mem_req_addr] : '0;
            if (bus.mem_req_op == Op_WRITE) mem[bus.mem_req_addr] <= bus.mem_req_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.req_op_0   = Op_INVALID;
        bus.req_addr_0 = '0;
        bus.req_data_0 = '0;
        bus.req_op_1   = Op_INVALID;
        bus.req_addr_1 = '0;
        bus.req_data_1 = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        bus.req_op_0 = Op_READ; bus.req_addr_0 = 6'h01;
        bus.req_op_1 = Op_READ; bus.req_addr_1 = 6'h02;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.mem_rst !== 1'b1) begin n_err++; $display("FAIL rst_mem_rst: got %b exp 1", bus.mem_rst); end
        n_vec++; if (bus.req_gnt_0 !== 1'b0 || bus.req_gnt_1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b%b exp 00", bus.req_gnt_1, bus.req_gnt_0); end
        n_vec++; if (bus.mem_req_op !== Op_INVALID) begin n_err++; $display("FAIL rst_mem_op: got %0d exp 0", bus.mem_req_op); end
        n_vec++; if (bus.mem_req_addr !== 6'h00 || bus.mem_req_data !== 8'h00) begin n_err++; $display("FAIL rst_mem_ad: got %h/%h exp 00/00", bus.mem_req_addr, bus.mem_req_data); end
        n_vec++; if (bus.rsp_vld_0 !== 1'b0 || bus.rsp_vld_1 !== 1'b0 || bus.rsp_data_0 !== 8'h00 || bus.rsp_data_1 !== 8'h00) begin
            n_err++; $display("FAIL rst_rsp: got vld %b%b data %h/%h exp 00 00/00", bus.rsp_vld_1, bus.rsp_vld_0, bus.rsp_data_0, bus.rsp_data_1); end
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_vec++; if (bus.mem_rst !== 1'b1) begin n_err++; $display("FAIL clr_mem_rst c%0d: got %b exp 1", c, bus.mem_rst); end
            n_vec++; if (bus.req_gnt_0 !== 1'b0 || bus.req_gnt_1 !== 1'b0) begin n_err++; $display("FAIL clr_gnt c%0d: got %b%b exp 00", c, bus.req_gnt_1, bus.req_gnt_0); end
            tick();
        end
        @(negedge clk);
        n_vec++; if (bus.mem_rst !== 1'b0) begin n_err++; $display("FAIL run_mem_rst: got %b exp 0", bus.mem_rst); end
        n_vec++; if (bus.req_gnt_0 !== 1'b1 || bus.req_gnt_1 !== 1'b0) begin n_err++; $display("FAIL first_gnt: got %b%b exp 01", bus.req_gnt_1, bus.req_gnt_0); end
        tick();
        bus.req_op_0 = Op_INVALID;
        @(negedge clk);
        n_vec++; if (bus.req_gnt_1 !== 1'b1 || bus.req_gnt_0 !== 1'b0) begin n_err++; $display("FAIL second_gnt: got %b%b exp 10", bus.req_gnt_1, bus.req_gnt_0); end
        n_vec++; if (bus.mem_req_op !== Op_READ || bus.mem_req_addr !== 6'h01) begin n_err++; $display("FAIL issue0: got op %0d addr %h exp 1 01", bus.mem_req_op, bus.mem_req_addr); end
        tick();
        bus.req_op_1 = Op_INVALID;
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_0 !== 1'b1 || bus.rsp_data_0 !== 8'h00 || bus.rsp_vld_1 !== 1'b0) begin
            n_err++; $display("FAIL unwritten_rd0: got vld %b%b data %h exp 01 00", bus.rsp_vld_1, bus.rsp_vld_0, bus.rsp_data_0); end
        n_vec++; if (bus.mem_req_op !== Op_READ || bus.mem_req_addr !== 6'h02) begin n_err++; $display("FAIL issue1: got op %0d addr %h exp 1 02", bus.mem_req_op, bus.mem_req_addr); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_1 !== 1'b1 || bus.rsp_data_1 !== 8'h00 || bus.rsp_vld_0 !== 1'b0) begin
            n_err++; $display("FAIL unwritten_rd1: got vld %b%b data %h exp 10 00", bus.rsp_vld_1, bus.rsp_vld_0, bus.rsp_data_1); end
        n_vec++; if (bus.mem_req_op !== Op_INVALID) begin n_err++; $display("FAIL idle_op: got %0d exp 0", bus.mem_req_op); end
        tick();
    endtask

    task automatic test_write_read;
        idle();
        bus.req_op_0 = Op_WRITE; bus.req_addr_0 = 6'h05; bus.req_data_0 = 8'hA5;
        @(negedge clk);
        n_vec++; if (bus.req_gnt_0 !== 1'b1 || bus.req_gnt_1 !== 1'b0) begin n_err++; $display("FAIL wr_gnt: got %b%b exp 01", bus.req_gnt_1, bus.req_gnt_0); end
        tick();
        idle();
        bus.req_op_1 = Op_READ; bus.req_addr_1 = 6'h05;
        @(negedge clk);
        n_vec++; if (bus.req_gnt_1 !== 1'b1 || bus.req_gnt_0 !== 1'b0) begin n_err++; $display("FAIL rd_gnt: got %b%b exp 10", bus.req_gnt_1, bus.req_gnt_0); end
        n_vec++; if (bus.mem_req_op !== Op_WRITE || bus.mem_req_addr !== 6'h05 || bus.mem_req_data !== 8'hA5) begin
            n_err++; $display("FAIL wr_issue: got op %0d addr %h data %h exp 2 05 a5", bus.mem_req_op, bus.mem_req_addr, bus.mem_req_data); end
        tick();
        idle();
        @(negedge clk);
        n_vec++; if (bus.mem_req_op !== Op_READ || bus.mem_req_addr !== 6'h05) begin n_err++; $display("FAIL rd_issue: got op %0d addr %h exp 1 05", bus.mem_req_op, bus.mem_req_addr); end
        n_vec++; if (bus.rsp_vld_0 !== 1'b0 || bus.rsp_vld_1 !== 1'b0) begin n_err++; $display("FAIL wr_no_rsp: got %b%b exp 00", bus.rsp_vld_1, bus.rsp_vld_0); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_1 !== 1'b1 || bus.rsp_data_1 !== 8'hA5) begin n_err++; $display("FAIL rd_rsp1: got vld %b data %h exp 1 a5", bus.rsp_vld_1, bus.rsp_data_1); end
        n_vec++; if (bus.rsp_vld_0 !== 1'b0 || bus.rsp_data_0 !== 8'h00) begin n_err++; $display("FAIL rd_rsp0_quiet: got vld %b data %h exp 0 00", bus.rsp_vld_0, bus.rsp_data_0); end
        tick();
    endtask

    task automatic test_alternate;
        logic exp_g0;
        logic exp_v0;
        logic exp_v1;
        idle();
        bus.req_op_0 = Op_WRITE; bus.req_addr_0 = 6'h01; bus.req_data_0 = 8'h11;
        bus.req_op_1 = Op_WRITE; bus.req_addr_1 = 6'h02; bus.req_data_1 = 8'h22;
        @(negedge clk);
        n_vec++; if (bus.req_gnt_0 !== 1'b1 || bus.req_gnt_1 !== 1'b0) begin n_err++; $display("FAIL alt_pre0: got %b%b exp 01", bus.req_gnt_1, bus.req_gnt_0); end
        tick();
        bus.req_op_0 = Op_READ; bus.req_data_0 = '0;
        @(negedge clk);
        n_vec++; if (bus.req_gnt_1 !== 1'b1 || bus.req_gnt_0 !== 1'b0) begin n_err++; $display("FAIL alt_pre1: got %b%b exp 10", bus.req_gnt_1, bus.req_gnt_0); end
        tick();
        bus.req_op_1 = Op_READ; bus.req_data_1 = '0;
        for (int i = 0; i < 6; i++) begin
            exp_g0 = ((i % 2) == 0);
            exp_v0 = (i >= 2) && exp_g0;
            exp_v1 = (i >= 2) && !exp_g0;
            @(negedge clk);
            n_vec++; if (bus.req_gnt_0 !== exp_g0 || bus.req_gnt_1 !== !exp_g0) begin
                n_err++; $display("FAIL alt_gnt c%0d: got %b%b exp %b%b", i, bus.req_gnt_1, bus.req_gnt_0, !exp_g0, exp_g0); end
            n_vec++; if (bus.rsp_vld_0 !== exp_v0 || bus.rsp_vld_1 !== exp_v1) begin
                n_err++; $display("FAIL alt_vld c%0d: got %b%b exp %b%b", i, bus.rsp_vld_1, bus.rsp_vld_0, exp_v1, exp_v0); end
            n_vec++; if (bus.rsp_data_0 !== (exp_v0 ? 8'h11 : 8'h00) || bus.rsp_data_1 !== (exp_v1 ? 8'h22 : 8'h00)) begin
                n_err++; $display("FAIL alt_data c%0d: got %h/%h exp %h/%h", i, bus.rsp_data_0, bus.rsp_data_1, exp_v0 ? 8'h11 : 8'h00, exp_v1 ? 8'h22 : 8'h00); end
            tick();
        end
        idle();
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_0 !== 1'b1 || bus.rsp_data_0 !== 8'h11 || bus.rsp_vld_1 !== 1'b0) begin
            n_err++; $display("FAIL alt_tail0: got vld %b%b data %h exp 01 11", bus.rsp_vld_1, bus.rsp_vld_0, bus.rsp_data_0); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_1 !== 1'b1 || bus.rsp_data_1 !== 8'h22 || bus.rsp_vld_0 !== 1'b0) begin
            n_err++; $display("FAIL alt_tail1: got vld %b%b data %h exp 10 22", bus.rsp_vld_1, bus.rsp_vld_0, bus.rsp_data_1); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] exp_d;
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.req_op_0 = Op_WRITE; bus.req_addr_0 = ADDR_W'(16 + i); bus.req_data_0 = DATA_W'(8'hB0 + i);
            @(negedge clk);
            n_vec++; if (bus.req_gnt_0 !== 1'b1) begin n_err++; $display("FAIL b2b_wr_gnt c%0d: got %b exp 1", i, bus.req_gnt_0); end
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.req_op_1 = Op_READ; bus.req_addr_1 = ADDR_W'(16 + i);
            end else begin
                idle();
            end
            exp_d = (i >= 2) ? DATA_W'(8'hB0 + i - 2) : 8'h00;
            @(negedge clk);
            if (i < 4) begin
                n_vec++; if (bus.req_gnt_1 !== 1'b1) begin n_err++; $display("FAIL b2b_rd_gnt c%0d: got %b exp 1", i, bus.req_gnt_1); end
            end
            n_vec++; if (bus.rsp_vld_1 !== (i >= 2) || bus.rsp_data_1 !== exp_d) begin
                n_err++; $display("FAIL b2b_rsp c%0d: got vld %b data %h exp %b %h", i, bus.rsp_vld_1, bus.rsp_data_1, (i >= 2), exp_d); end
            n_vec++; if (bus.rsp_vld_0 !== 1'b0) begin n_err++; $display("FAIL b2b_rsp0 c%0d: got %b exp 0", i, bus.rsp_vld_0); end
            tick();
        end
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_1 !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b exp 0", bus.rsp_vld_1); end
        tick();
    endtask

    task automatic test_reset_mid;
        idle();
        bus.req_op_1 = Op_READ; bus.req_addr_1 = 6'h05;
        @(negedge clk);
        n_vec++; if (bus.req_gnt_1 !== 1'b1) begin n_err++; $display("FAIL mid_gnt: got %b exp 1", bus.req_gnt_1); end
        tick();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        n_vec++; if (bus.mem_req_op !== Op_INVALID || bus.mem_rst !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_state: got op %0d mem_rst %b exp 0 1", bus.mem_req_op, bus.mem_rst); end
        n_vec++; if (bus.rsp_vld_0 !== 1'b0 || bus.rsp_vld_1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_rsp: got %b%b exp 00", bus.rsp_vld_1, bus.rsp_vld_0); end
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) begin
                bus.req_op_0 = Op_READ; bus.req_addr_0 = 6'h05;
            end else if (c == 4) begin
                idle();
            end
            @(negedge clk);
            n_vec++; if (bus.mem_rst !== (c < 3)) begin n_err++; $display("FAIL mid_clr c%0d: got %b exp %b", c, bus.mem_rst, (c < 3)); end
            n_vec++; if (bus.rsp_vld_0 !== 1'b0 || bus.rsp_vld_1 !== 1'b0) begin n_err++; $display("FAIL mid_drop c%0d: got %b%b exp 00", c, bus.rsp_vld_1, bus.rsp_vld_0); end
            if (c == 3) begin
                n_vec++; if (bus.req_gnt_0 !== 1'b1 || bus.req_gnt_1 !== 1'b0) begin n_err++; $display("FAIL mid_regnt: got %b%b exp 01", bus.req_gnt_1, bus.req_gnt_0); end
            end
            tick();
        end
        @(negedge clk);
        n_vec++; if (bus.rsp_vld_0 !== 1'b1 || bus.rsp_data_0 !== 8'h00) begin
            n_err++; $display("FAIL mid_cleared: got vld %b data %h exp 1 00", bus.rsp_vld_0, bus.rsp_data_0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
